// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator slice.
// Clock rate, default widths and the allocator FSM state encoding.
package synth_pkg;

    localparam int CLK_HZ     = 1_000_000;
    localparam int FREQ_W_DEF = 12;
    localparam int AGE_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice: gate, frequency word and saturating age.
// load takes precedence over release, retrigger and aging.
module voice_slot
    import synth_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int AGE_W  = AGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              retrig,
    input  logic              release_gate,
    input  logic              age_inc,
    input  logic [FREQ_W-1:0] new_freq,
    output logic              gate,
    output logic [FREQ_W-1:0] freq,
    output logic [AGE_W-1:0]  age
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate <= 1'b0;
            freq <= '0;
            age  <= '0;
        end else if (load) begin
            gate <= 1'b1;
            freq <= new_freq;
            age  <= '0;
        end else begin
            if (release_gate) gate <= 1'b0;
            if (retrig) begin
                age <= '0;
            end else if (age_inc && age != '1) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential scan of the voice bank, then commit.
// Define VOICE_STEAL_EN to steal the oldest voice when the bank is full.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = FREQ_W_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evt_valid,
    output logic                         evt_ready,
    input  logic                         evt_on,
    input  logic [FREQ_W-1:0]            evt_freq,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
    output logic                         steal_pulse,
    output logic                         drop_pulse
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES+1);

    alloc_state_t state, state_nx;
    logic [IW-1:0] idx;
    logic lat_on;
    logic [FREQ_W-1:0] lat_freq;
    logic match_ok, free_ok;
    logic [IW-1:0] match_idx, free_idx;

    logic [NUM_VOICES-1:0] gate;
    logic [FREQ_W-1:0] freq [NUM_VOICES];
    logic [AGE_W-1:0] age [NUM_VOICES];
    logic [NUM_VOICES-1:0] load, retrig, rel, age_inc;
    logic [NUM_VOICES-1:0] gate_nx, tgt_mask;
    logic [CW-1:0] cnt_nx;
    logic tgt_ok, drop_nx;
    logic [IW-1:0] tgt;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(.FREQ_W(FREQ_W), .AGE_W(AGE_W)) u_slot (
            .clk(clk),
            .rst_n(rst_n),
            .load(load[i]),
            .retrig(retrig[i]),
            .release_gate(rel[i]),
            .age_inc(age_inc[i]),
            .new_freq(lat_freq),
            .gate(gate[i]),
            .freq(freq[i]),
            .age(age[i])
        );
        assign voice_freq[i*FREQ_W +: FREQ_W] = freq[i];
    end

    assign voice_gate = gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        evt_ready = 1'b0;
        unique case (state)
            IDLE: begin
                evt_ready = 1'b1;
                if (evt_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (idx == IW'(NUM_VOICES-1)) state_nx = COMMIT;
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef VOICE_STEAL_EN
    logic old_ok;
    logic [IW-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic steal_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_ok  <= 1'b0;
            old_idx <= '0;
            old_age <= '0;
        end else if (state == IDLE && evt_valid) begin
            old_ok <= 1'b0;
        end else if (state == SCAN && gate[idx]) begin
            // Strict compare keeps the lowest index on equal ages
            if (!old_ok || age[idx] > old_age) begin
                old_ok  <= 1'b1;
                old_idx <= idx;
                old_age <= age[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              steal_pulse <= 1'b0;
        else if (state == COMMIT) steal_pulse <= steal_nx;
        else                     steal_pulse <= 1'b0;
    end
`else
    logic unused_age;
    always_comb begin
        unused_age = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) unused_age ^= ^age[i];
    end
    assign steal_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            lat_on    <= 1'b0;
            lat_freq  <= '0;
            match_ok  <= 1'b0;
            match_idx <= '0;
            free_ok   <= 1'b0;
            free_idx  <= '0;
        end else if (state == IDLE && evt_valid) begin
            idx      <= '0;
            lat_on   <= evt_on;
            lat_freq <= evt_freq;
            match_ok <= 1'b0;
            free_ok  <= 1'b0;
        end else if (state == SCAN) begin
            idx <= idx + 1'b1;
            if (!match_ok && gate[idx] && freq[idx] == lat_freq) begin
                match_ok  <= 1'b1;
                match_idx <= idx;
            end
            if (!free_ok && !gate[idx]) begin
                free_ok  <= 1'b1;
                free_idx <= idx;
            end
        end
    end

    always_comb begin
        load    = '0;
        retrig  = '0;
        rel     = '0;
        age_inc = '0;
        drop_nx = 1'b0;
        tgt_ok  = 1'b0;
        tgt     = '0;
`ifdef VOICE_STEAL_EN
        steal_nx = 1'b0;
`endif
        if (state == COMMIT) begin
            if (lat_on) begin
                if (lat_freq == '0) begin
                    drop_nx = 1'b1;
                end else if (match_ok) begin
                    retrig[match_idx] = 1'b1;
                    tgt_ok = 1'b1;
                    tgt    = match_idx;
                end else if (free_ok) begin
                    load[free_idx] = 1'b1;
                    tgt_ok = 1'b1;
                    tgt    = free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    load[old_idx] = 1'b1;
                    steal_nx = 1'b1;
                    tgt_ok   = 1'b1;
                    tgt      = old_idx;
`else
                    drop_nx = 1'b1;
`endif
                end
            end else if (match_ok) begin
                rel[match_idx] = 1'b1;
            end
        end
        tgt_mask      = '0;
        tgt_mask[tgt] = 1'b1;
        if (tgt_ok) age_inc = gate & ~tgt_mask;
    end

    always_comb begin
        gate_nx = (gate | load) & ~rel;
        cnt_nx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) cnt_nx = cnt_nx + CW'(gate_nx[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_count <= '0;
            drop_pulse   <= 1'b0;
        end else if (state == COMMIT) begin
            active_count <= cnt_nx;
            drop_pulse   <= drop_nx;
        end else begin
            drop_pulse <= 1'b0;
        end
    end

endmodule
